// File: rtl/intersection_sequencer_if.sv
// Signal bundle between the intersection sequencer and its surroundings:
// timing strobe and pedestrian button in, lamp drives and debug phase out.
interface intersection_sequencer_if;
    logic       tick;
    logic       ped_req;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick, ped_req,
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        input  walk, ped_pending, phase
    );

    modport slave (
        input  tick, ped_req,
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
        output walk, ped_pending, phase
    );
endinterface

// File: rtl/intersection_sequencer.sv
// Two-road intersection sequencer: NS/EW signal heads, all-red clearances and
// an on-demand pedestrian walk phase, all timed in tick strobes.
module intersection_sequencer #(
    parameter int NS_GREEN_T = 10,
    parameter int EW_GREEN_T = 4,
    parameter int YELLOW_T   = 3,
    parameter int RED_T      = 1,
    parameter int WALK_T     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    intersection_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        NS_GO   = 3'd0,
        NS_WARN = 3'd1,
        CLR_A   = 3'd2,
        WALK_A  = 3'd3,
        EW_GO   = 3'd4,
        EW_WARN = 3'd5,
        CLR_B   = 3'd6,
        WALK_B  = 3'd7
    } state_e;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ped_q, ped_d;
    lamps_t     lamps_q, lamps_d;
    logic       phase_end;

    function automatic logic [3:0] dur(input state_e s);
        case (s)
            NS_GO:            dur = 4'(NS_GREEN_T);
            EW_GO:            dur = 4'(EW_GREEN_T);
            NS_WARN, EW_WARN: dur = 4'(YELLOW_T);
            CLR_A, CLR_B:     dur = 4'(RED_T);
            default:          dur = 4'(WALK_T);
        endcase
    endfunction

    function automatic logic is_walk(input state_e s);
        is_walk = (s == WALK_A) || (s == WALK_B);
    endfunction

    // Clearances branch into a walk only for requests already latched.
    function automatic state_e next_state(input state_e s, input logic ped);
        case (s)
            NS_GO:   next_state = NS_WARN;
            NS_WARN: next_state = CLR_A;
            CLR_A:   next_state = ped ? WALK_A : EW_GO;
            WALK_A:  next_state = EW_GO;
            EW_GO:   next_state = EW_WARN;
            EW_WARN: next_state = CLR_B;
            CLR_B:   next_state = ped ? WALK_B : NS_GO;
            default: next_state = NS_GO;
        endcase
    endfunction

    function automatic lamps_t decode(input state_e s);
        decode = '{ns_red: 1'b1, ew_red: 1'b1, default: 1'b0};
        case (s)
            NS_GO:   begin decode.ns_red = 1'b0; decode.ns_green  = 1'b1; end
            NS_WARN: begin decode.ns_red = 1'b0; decode.ns_yellow = 1'b1; end
            EW_GO:   begin decode.ew_red = 1'b0; decode.ew_green  = 1'b1; end
            EW_WARN: begin decode.ew_red = 1'b0; decode.ew_yellow = 1'b1; end
            WALK_A, WALK_B: decode.walk = 1'b1;
            default: ;
        endcase
    endfunction

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ped_d     = ped_q;
        phase_end = bus.tick && (cnt_q == dur(state_q) - 4'd1);

        if (bus.ped_req && !is_walk(state_q)) begin
            ped_d = 1'b1;
        end

        if (phase_end) begin
            state_d = next_state(state_q, ped_q);
            cnt_d   = '0;
            // Entering a walk serves the request and beats a same-edge press.
            if (is_walk(state_d)) begin
                ped_d = 1'b0;
            end
        end else if (bus.tick) begin
            cnt_d = cnt_q + 4'd1;
        end

        lamps_d = decode(state_d);
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLR_B;
            cnt_q   <= '0;
            ped_q   <= 1'b0;
            lamps_q <= decode(CLR_B);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
            lamps_q <= lamps_d;
        end
    end

    assign bus.ns_red      = lamps_q.ns_red;
    assign bus.ns_yellow   = lamps_q.ns_yellow;
    assign bus.ns_green    = lamps_q.ns_green;
    assign bus.ew_red      = lamps_q.ew_red;
    assign bus.ew_yellow   = lamps_q.ew_yellow;
    assign bus.ew_green    = lamps_q.ew_green;
    assign bus.walk        = lamps_q.walk;
    assign bus.ped_pending = ped_q;
    assign bus.phase       = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Bench for intersection_sequencer: per-cycle scoreboard against a tick-level
// reference model, a phase-sequence table and hand-written pedestrian cases.
module tb_intersection_sequencer;

    localparam int NS_G = 10, EW_G = 4, YEL = 3, RED = 1, WLK = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    intersection_sequencer_if bus ();

    intersection_sequencer #(
        .NS_GREEN_T(NS_G), .EW_GREEN_T(EW_G), .YELLOW_T(YEL), .RED_T(RED), .WALK_T(WLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] phase;
        logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, pend;
    } obs_t;

    typedef struct {
        bit         rst;
        bit         tk;
        bit         pr;
        logic [2:0] exp_phase;
        int         reps;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];
    vec_t tab[13];

    // Reference model: elapsed ticks in the current phase plus the request latch.
    int m_phase = 6;
    int m_elapsed = 0;
    bit m_ped = 1'b0;
    int dur_tab[8] = '{NS_G, YEL, RED, WLK, EW_G, YEL, RED, WLK};

    function automatic int m_next(input int p, input bit ped);
        case (p)
            2:       m_next = ped ? 3 : 4;
            6:       m_next = ped ? 7 : 0;
            3:       m_next = 4;
            7:       m_next = 0;
            default: m_next = p + 1;
        endcase
    endfunction

    task automatic model(input bit r, input bit t, input bit p);
        bit np;
        int nx;
        if (r) begin
            m_phase = 6; m_elapsed = 0; m_ped = 1'b0;
            return;
        end
        np = m_ped | (p && m_phase != 3 && m_phase != 7);
        if (t) begin
            if (m_elapsed + 1 == dur_tab[m_phase]) begin
                nx = m_next(m_phase, m_ped);
                if (nx == 3 || nx == 7) np = 1'b0;
                m_phase = nx;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        m_ped = np;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.phase = 3'(m_phase);
        o.ns_g  = (m_phase == 0);
        o.ns_y  = (m_phase == 1);
        o.ns_r  = !(o.ns_g || o.ns_y);
        o.ew_g  = (m_phase == 4);
        o.ew_y  = (m_phase == 5);
        o.ew_r  = !(o.ew_g || o.ew_y);
        o.walk  = (m_phase == 3) || (m_phase == 7);
        o.pend  = m_ped;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{bus.phase, bus.ns_red, bus.ns_yellow, bus.ns_green,
              bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk, bus.ped_pending};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, queue the model's prediction, compare after the edge.
    task automatic step(input bit r, input bit t, input bit p);
        obs_t a;
        reset = r;
        bus.tick = t;
        bus.ped_req = p;
        model(r, t, p);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        a = sample();
        check("scoreboard", 32'(a), 32'(exp_q.pop_front()));
        check("dual_green", 32'(a.ns_g & a.ew_g), 32'd0);
    endtask

    task automatic wait_phase(input logic [2:0] target, input bit t, input bit p, input int budget);
        int n = 0;
        while (bus.phase !== target && n < budget) begin
            step(1'b0, t, p);
            n++;
        end
        check("wait_phase", 32'(bus.phase), 32'(target));
    endtask

    task automatic run_table(input int start);
        for (int i = start; i < 13; i++) begin
            for (int k = 0; k < tab[i].reps; k++) begin
                step(tab[i].rst, tab[i].tk, tab[i].pr);
                check("tab_phase", 32'(bus.phase), 32'(tab[i].exp_phase));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t snap;
        int   cnt;
        bit   first_walk_pend;
        bit   seen_walk;

        tab[0] = '{1'b1, 1'b1, 1'b0, 3'd6, 1};
        for (int c = 0; c < 2; c++) begin
            tab[1 + 6*c] = '{1'b0, 1'b1, 1'b0, 3'd0, NS_G};
            tab[2 + 6*c] = '{1'b0, 1'b1, 1'b0, 3'd1, YEL};
            tab[3 + 6*c] = '{1'b0, 1'b1, 1'b0, 3'd2, RED};
            tab[4 + 6*c] = '{1'b0, 1'b1, 1'b0, 3'd4, EW_G};
            tab[5 + 6*c] = '{1'b0, 1'b1, 1'b0, 3'd5, YEL};
            tab[6 + 6*c] = '{1'b0, 1'b1, 1'b0, 3'd6, RED};
        end
        bus.tick = 1'b0;
        bus.ped_req = 1'b0;

        // Reset with tick held high: two full 22-tick cycles.
        run_table(0);
        check("reset_ns_red", 32'(bus.ns_red), 32'd1);

        // Tick every 4 clocks: NS_GO spans 40 clocks; then a 100-clock freeze.
        step(1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, (i % 4) == 3, 1'b0);
            if (bus.phase == 3'd0) cnt++;
        end
        check("ns_go_clocks", 32'(cnt), 32'd40);
        snap = sample();
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0);
        check("frozen", 32'(sample()), 32'(snap));

        // Single-cycle request during NS_GO is served at CLR_A.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("pend_next_cycle", 32'(bus.ped_pending), 32'd1);
        cnt = 0;
        seen_walk = 1'b0;
        first_walk_pend = 1'b1;
        for (int i = 0; i < 40 && bus.phase != 3'd4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (bus.walk) begin
                if (!seen_walk) first_walk_pend = bus.ped_pending;
                seen_walk = 1'b1;
                cnt++;
            end
        end
        check("walk_a_ticks", 32'(cnt), 32'(WLK));
        check("pend_clear_on_walk", 32'(first_walk_pend), 32'd0);
        check("after_walk_a", 32'(bus.phase), 32'd4);

        // Request on the edge leaving CLR_A is deferred to CLR_B.
        step(1'b1, 1'b1, 1'b0);
        wait_phase(3'd2, 1'b1, 1'b0, 40);
        step(1'b0, 1'b1, 1'b1);
        check("late_req_phase", 32'(bus.phase), 32'd4);
        check("late_req_pend", 32'(bus.ped_pending), 32'd1);
        wait_phase(3'd6, 1'b1, 1'b0, 40);
        step(1'b0, 1'b1, 1'b0);
        check("walk_b_follows", 32'(bus.phase), 32'd7);

        // Request held high through WALK_B re-latches only after NS_GO entry.
        wait_phase(3'd0, 1'b1, 1'b1, 20);
        check("pend_at_ns_go_entry", 32'(bus.ped_pending), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("pend_relatched", 32'(bus.ped_pending), 32'd1);
        wait_phase(3'd2, 1'b1, 1'b0, 40);
        step(1'b0, 1'b1, 1'b0);
        check("walk_a_follows", 32'(bus.phase), 32'd3);

        // Reset mid-EW_GO with counter at 2, then the normal sequence restarts.
        step(1'b1, 1'b1, 1'b0);
        wait_phase(3'd4, 1'b1, 1'b0, 40);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("mid_reset_phase", 32'(bus.phase), 32'd6);
        check("mid_reset_reds", 32'({bus.ns_red, bus.ew_red}), 32'd3);
        check("mid_reset_greens", 32'({bus.ns_green, bus.ew_green}), 32'd0);
        check("mid_reset_walk", 32'(bus.walk), 32'd0);
        check("mid_reset_pend", 32'(bus.ped_pending), 32'd0);
        run_table(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
